// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Hazard/stall controller for a 5-stage RISC-V pipeline. Drives
//            the stage-register enables and flushes, sequences mul/div
//            occupancy of EX, and counts the cycles in which the PC is stalled.
// Revision : 1.0
// ============================================================================
module pipe_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int REGW      = 5,
    parameter int CNTW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_br_taken,
    input  logic            ex_md_start,
    input  logic            if_ready,
    input  logic            mem_req_valid,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            if_id_en,
    output logic            id_ex_en,
    output logic            ex_mem_en,
    output logic            mem_wb_en,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            ex_mem_flush,
    output logic            mem_wb_flush,
    output logic            md_busy,
    output logic [CNTW-1:0] stall_cnt
);

    localparam int              c_MDW     = 4;
    localparam logic            c_MD_MULTI = (MD_CYCLES > 1);
    localparam logic [c_MDW-1:0] c_MD_LOAD = c_MDW'((MD_CYCLES > 1) ? (MD_CYCLES - 2) : 0);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_MDW-1:0]   r_md_cnt;
    logic [c_MDW-1:0]   w_md_cnt_nxt;
    logic [CNTW-1:0]    r_stall_cnt;

    logic w_memstall;
    logic w_loaduse;
    logic w_in_md;
    logic w_redirect;
    logic w_md_hold;
    logic w_md_done;

    assign w_memstall = mem_req_valid & ~mem_ready;
    assign w_loaduse  = ex_mem_read & (ex_rd != '0) &
                        ((id_rs1_used & (id_rs1 == ex_rd)) |
                         (id_rs2_used & (id_rs2 == ex_rd)));
    assign w_in_md    = (r_state == ST_MD_BUSY);
    // A branch outcome is only trustworthy when EX holds a normal instruction.
    assign w_redirect = ex_br_taken & ~w_in_md & ~ex_md_start;
    assign w_md_hold  = (~w_in_md & ex_md_start & c_MD_MULTI) |
                        (w_in_md & (r_md_cnt != '0));
    assign w_md_done  = w_in_md & (r_md_cnt == '0);

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (w_memstall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (w_md_hold) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (w_md_done) begin
            pc_en = 1'b1;
        end else if (w_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_loaduse) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!if_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    assign md_busy   = w_in_md & ~rst;
    assign stall_cnt = r_stall_cnt;

    // The mul/div unit keeps counting through memory stalls; only the exit waits.
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        case (r_state)
            ST_RUN: begin
                if (ex_md_start & c_MD_MULTI & ~w_memstall & ~w_redirect) begin
                    w_state_nxt  = ST_MD_BUSY;
                    w_md_cnt_nxt = c_MD_LOAD;
                end
            end
            ST_MD_BUSY: begin
                if (r_md_cnt != '0) begin
                    w_md_cnt_nxt = r_md_cnt - 1'b1;
                end else if (!w_memstall) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_md_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            if (!pc_en) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Directed-vector scoreboard bench for pipe_ctrl (MD_CYCLES=4).
// Revision : 1.0
// ============================================================================
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used;
    logic        ex_mem_read, ex_br_taken, ex_md_start;
    logic        if_ready, mem_req_valid, mem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        md_busy;
    logic [31:0] stall_cnt;

    pipe_ctrl #(.MD_CYCLES(4), .REGW(5), .CNTW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_br_taken  (ex_br_taken),
        .ex_md_start  (ex_md_start),
        .if_ready     (if_ready),
        .mem_req_valid(mem_req_valid),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_flush (mem_wb_flush),
        .md_busy      (md_busy),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc, if_id, id_ex, ex_mem, mem_wb} en, {if_id, id_ex, ex_mem, mem_wb} flush, md_busy
    localparam logic [9:0] c_RST   = 10'b00000_0000_0;
    localparam logic [9:0] c_RUN   = 10'b11111_0000_0;
    localparam logic [9:0] c_LU    = 10'b00111_0100_0;
    localparam logic [9:0] c_NOF   = 10'b01111_1000_0;
    localparam logic [9:0] c_REDIR = 10'b11111_1100_0;
    localparam logic [9:0] c_MS    = 10'b00001_0001_0;
    localparam logic [9:0] c_MSB   = 10'b00001_0001_1;
    localparam logic [9:0] c_MDH   = 10'b00011_0010_0;
    localparam logic [9:0] c_MDHB  = 10'b00011_0010_1;
    localparam logic [9:0] c_MDC   = 10'b11111_0000_1;

    typedef struct {
        string       name;
        logic [9:0]  ctrl;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    wire [9:0] w_got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_busy};

    // Monitor: every cycle with a pending expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (w_got !== e.ctrl) begin
                n_bad++;
                $display("FAIL %s ctrl: got %b expected %b", e.name, w_got, e.ctrl);
            end
            n_cmp++;
            if (stall_cnt !== e.cnt) begin
                n_bad++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt);
            end
        end
    end

    task automatic defaults();
        rst           = 1'b0;
        id_rs1        = '0;
        id_rs2        = '0;
        ex_rd         = '0;
        id_rs1_used   = 1'b0;
        id_rs2_used   = 1'b0;
        ex_mem_read   = 1'b0;
        ex_br_taken   = 1'b0;
        ex_md_start   = 1'b0;
        if_ready      = 1'b1;
        mem_req_valid = 1'b0;
        mem_ready     = 1'b1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        defaults();
    endtask

    task automatic expect_v(input string nm, input logic [9:0] ctrl, input logic [31:0] cnt);
        exp_t e;
        e.name = nm;
        e.ctrl = ctrl;
        e.cnt  = cnt;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        defaults();
        rst = 1'b1;
        @(posedge clk);

        nxt(); rst = 1'b1; expect_v("reset", c_RST, 0);

        for (int i = 0; i < 10; i++) begin
            nxt(); expect_v("idle", c_RUN, 0);
        end

        nxt(); ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
        expect_v("loaduse_rs2", c_LU, 0);
        nxt(); expect_v("after_lu", c_RUN, 1);

        nxt(); ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 1;
        expect_v("loaduse_rs1", c_LU, 1);
        nxt(); expect_v("after_lu2", c_RUN, 2);

        nxt(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
        expect_v("lu_x0", c_RUN, 2);
        nxt(); ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_rs2_used = 0;
        expect_v("lu_unused", c_RUN, 2);
        nxt(); ex_mem_read = 0; ex_rd = 9; id_rs1 = 9; id_rs1_used = 1;
        expect_v("lu_noload", c_RUN, 2);

        nxt(); if_ready = 0; expect_v("nofetch", c_NOF, 2);
        nxt(); expect_v("after_nof", c_RUN, 3);

        nxt(); ex_md_start = 1; expect_v("md1", c_MDH, 3);
        nxt(); ex_md_start = 1; expect_v("md2", c_MDHB, 4);
        nxt(); ex_md_start = 1; expect_v("md3", c_MDHB, 5);
        nxt(); ex_md_start = 1; expect_v("md_done", c_MDC, 6);
        nxt(); expect_v("after_md", c_RUN, 6);

        nxt(); ex_md_start = 1; expect_v("mdm1", c_MDH, 6);
        nxt(); ex_md_start = 1; expect_v("mdm2", c_MDHB, 7);
        for (int i = 0; i < 3; i++) begin
            nxt(); ex_md_start = 1; mem_req_valid = 1; mem_ready = 0;
            expect_v("mdm_memstall", c_MSB, 8 + i);
        end
        nxt(); ex_md_start = 1; mem_req_valid = 1; mem_ready = 1;
        expect_v("mdm_done", c_MDC, 11);
        nxt(); expect_v("after_mdm", c_RUN, 11);

        nxt(); ex_br_taken = 1; if_ready = 0; ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
        expect_v("redir_over_lu", c_REDIR, 11);
        nxt(); expect_v("after_redir", c_RUN, 11);

        nxt(); ex_br_taken = 1; mem_req_valid = 1; mem_ready = 0;
        expect_v("ms_br1", c_MS, 11);
        nxt(); ex_br_taken = 1; mem_req_valid = 1; mem_ready = 0;
        expect_v("ms_br2", c_MS, 12);
        nxt(); ex_br_taken = 1; expect_v("br_after_ms", c_REDIR, 13);
        nxt(); expect_v("after_ms_br", c_RUN, 13);

        nxt(); ex_md_start = 1; expect_v("mdb1", c_MDH, 13);
        nxt(); ex_br_taken = 1; expect_v("mdb2_br", c_MDHB, 14);
        nxt(); ex_br_taken = 1; expect_v("mdb3_br", c_MDHB, 15);
        nxt(); ex_br_taken = 1; expect_v("mdb_done_br", c_MDC, 16);
        nxt(); expect_v("after_mdb", c_RUN, 16);

        nxt(); ex_md_start = 1; expect_v("mdr1", c_MDH, 16);
        nxt(); ex_md_start = 1; expect_v("mdr2", c_MDHB, 17);
        nxt(); ex_md_start = 1; rst = 1; expect_v("mdr_rst", c_RST, 18);
        nxt(); expect_v("post_rst1", c_RUN, 0);
        nxt(); expect_v("post_rst2", c_RUN, 0);
        nxt(); ex_mem_read = 1; ex_rd = 4; id_rs2 = 4; id_rs2_used = 1;
        expect_v("post_rst_lu", c_LU, 0);
        nxt(); expect_v("post_rst_run", c_RUN, 1);

        for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
